// File: rtl/mem_port_arbiter.sv
// Three-requester round-robin arbiter in front of a single-ported RAM.
// One transaction in flight at a time: IDLE grants, ACCESS waits for ram_ready or times out, RESP pulses the winner.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [2:0]             req_ren,
  input  logic [2:0]             req_wen,
  input  logic [2:0][ADDR_W-1:0] req_addr,
  input  logic [2:0][DATA_W-1:0] req_store,
  output logic [2:0]             req_ready,
  output logic                   req_err,
  output logic [DATA_W-1:0]      req_load,
  output logic                   ram_ren,
  output logic                   ram_wen,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_store,
  input  logic                   ram_ready,
  input  logic [DATA_W-1:0]      ram_load,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // The counter holds the number of ACCESS cycles already waited, so the
  // TIMEOUT-th waiting cycle is the one where it equals TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [1:0] last_grant;
  logic [1:0] gnt_idx;
  logic [7:0] wait_cnt;
  logic       is_write;

  logic [2:0] pending;
  logic       gnt_vld;
  logic [1:0] gnt_sel;
  logic [1:0] idx;

  assign pending = req_ren | req_wen;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_sel = 2'd0;
    idx     = last_grant;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (!gnt_vld && pending[idx]) begin
        gnt_vld = 1'b1;
        gnt_sel = idx;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      last_grant <= 2'd2;
      gnt_idx    <= 2'd0;
      wait_cnt   <= 8'd0;
      is_write   <= 1'b0;
      req_ready  <= 3'b000;
      req_err    <= 1'b0;
      req_load   <= '0;
      ram_ren    <= 1'b0;
      ram_wen    <= 1'b0;
      ram_addr   <= '0;
      ram_store  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            gnt_idx   <= gnt_sel;
            ram_addr  <= req_addr[gnt_sel];
            ram_store <= req_store[gnt_sel];
            is_write  <= req_wen[gnt_sel];
            ram_wen   <= req_wen[gnt_sel];
            ram_ren   <= ~req_wen[gnt_sel];
            wait_cnt  <= 8'd0;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (ram_ready || wait_cnt == CNT_LAST) begin
            req_err   <= ~ram_ready;
            req_load  <= (ram_ready && !is_write) ? ram_load : '0;
            req_ready <= 3'(3'b001 << gnt_idx);
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          req_ready  <= 3'b000;
          last_grant <= gnt_idx;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of request and RAM address.
REQ-002 SHALL have parameter DATA_W, default 32, width of store and load data.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles waited for ram_ready before an error response.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_ren  input  3  per-requester read request (bit0 icache, bit1 dcache, bit2 scratchpad).
REQ-007 SHALL have port req_wen  input  3  per-requester write request.
REQ-008 SHALL have port req_addr  input  3xADDR_W  per-requester address.
REQ-009 SHALL have port req_store  input  3xDATA_W  per-requester write data.
REQ-010 SHALL have port req_ready  output  3  one-hot, one-cycle completion pulse.
REQ-011 SHALL have port req_err  output  1  valid with req_ready; 1 = timeout.
REQ-012 SHALL have port req_load  output  DATA_W  read data, valid with req_ready.
REQ-013 SHALL have port ram_ren, ram_wen  output  1 each  RAM strobes.
REQ-014 SHALL have port ram_addr  output  ADDR_W; ram_store  output  DATA_W.
REQ-015 SHALL have port ram_ready  input  1; ram_load  input  DATA_W.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-018 In IDLE, SHALL treat requester i as pending when req_ren[i] or req_wen[i] is high.
REQ-019 In IDLE, SHALL grant by round-robin: search order starts at last_grant+1 mod 3; last_grant resets to 2, so bit0 wins first.
REQ-020 On grant, SHALL latch index, address, store data and op, then enter ACCESS next cycle.
REQ-021 SHALL treat a requester with ren and wen both high as a write.
REQ-022 In ACCESS, SHALL drive ram_ren/ram_wen, ram_addr and ram_store from the latched values only, never from live inputs.
REQ-023 In ACCESS, SHALL increment an 8-bit wait counter each cycle ram_ready is low.
REQ-024 In ACCESS, when ram_ready is high, SHALL capture ram_load (reads), clear err and enter RESP.
REQ-025 In ACCESS, when the counter reaches TIMEOUT and ram_ready is low, SHALL set err, set load to 0 and enter RESP.
REQ-026 ram_ready arriving in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-027 In RESP, SHALL pulse req_ready[granted] for exactly one cycle, drive req_load/req_err, update last_grant, deassert RAM strobes, then return to IDLE.
REQ-028 RAM strobes SHALL be low in IDLE and RESP.
REQ-029 Minimum latency SHALL be: request seen at cycle 0 -> strobes cycle 1 -> ram_ready cycle 1 -> req_ready cycle 2.
REQ-030 A requester dropping its request during ACCESS SHALL NOT abort the transaction; the ready pulse still occurs.
REQ-031 Requests arriving during ACCESS/RESP SHALL be held off; requesters keep them asserted until ready.
REQ-032 Back-to-back: a request pending in the RESP cycle SHALL be granted in the following IDLE cycle, giving one idle cycle between RAM accesses.

Reset
REQ-033 While RST is high, SHALL set state IDLE, last_grant 2, counter 0, and all outputs (req_ready, req_err, req_load, ram_ren, ram_wen, ram_addr, ram_store, busy) to 0.
REQ-034 RST asserted mid-ACCESS SHALL drop strobes immediately (asynchronous) and produce no ready pulse; the transaction is lost.

Verification
REQ-035 Single read: req_ren=3'b010, addr 0x100, ram_ready high one cycle later with ram_load 0xDEADBEEF -> req_ready=3'b010 with req_load 0xDEADBEEF at cycle 2, err 0.
REQ-036 All three requesting continuously, ram_ready always high -> grant order 0,1,2,0,1,2, each ready 3 cycles apart.
REQ-037 Write with ren=wen=1 on bit2, store 0x12345678 -> ram_wen=1, ram_ren=0, ram_store 0x12345678.
REQ-038 ram_ready held low, TIMEOUT=4 -> req_ready pulses with err=1 and load 0 after 4 ACCESS cycles; ram_ready on the 4th cycle -> err=0.
REQ-039 RST pulsed during ACCESS -> strobes 0 same cycle, no req_ready, next grant goes to bit0.
REQ-040 Requester 1 drops its request mid-ACCESS while requester 0 asserts a new one -> ready for 1 still pulses; 0 is granted next.
